// File: rtl/stream_run_sequencer_if.sv
// stream_run_sequencer_if: host command stream in, network packet stream out,
// plus the busy/steps status of the sequencer.
interface stream_run_sequencer_if #(
    parameter int NUM_INP      = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int NUM_FLG      = 2,
    parameter int RUN_WIDTH    = 16,
    parameter int CNT_WIDTH    = 32
);
    localparam int CMD_W = NUM_FLG + RUN_WIDTH + NUM_INP * CHARGE_WIDTH;
    localparam int SRC_W = NUM_FLG + NUM_INP * CHARGE_WIDTH;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_W-1:0]     cmd;
    logic                 src_valid;
    logic                 src_ready;
    logic [SRC_W-1:0]     src;
    logic                 busy;
    logic [CNT_WIDTH-1:0] steps;

    modport master (
        input  cmd_valid, cmd, src_ready,
        output cmd_ready, src_valid, src, busy, steps
    );

    modport slave (
        output cmd_valid, cmd, src_ready,
        input  cmd_ready, src_valid, src, busy, steps
    );
endinterface

// File: rtl/stream_run_sequencer.sv
// stream_run_sequencer: expands one host run command into N network packets;
// charges and CLR ride on the first packet, FIN on the last.
module stream_run_sequencer #(
    parameter int NUM_INP      = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int NUM_FLG      = 2,
    parameter int RUN_WIDTH    = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    stream_run_sequencer_if.master bus
);
    localparam int CHG_W = NUM_INP * CHARGE_WIDTH;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]           r_state;
    logic                 r_cmd_ready;
    logic                 r_clr_pend;
    logic                 r_fin_req;
    logic                 r_first;
    logic [RUN_WIDTH-1:0] r_rem;
    logic [CHG_W-1:0]     r_chg;
    logic [CNT_WIDTH-1:0] r_steps;

    logic [NUM_FLG-1:0]   w_cmd_flags;
    logic [NUM_FLG-1:0]   w_src_flags;
    logic [RUN_WIDTH-1:0] w_cmd_run;
    logic                 w_cmd_acc;
    logic                 w_beat_acc;
    logic                 w_last;

    assign w_cmd_flags = bus.cmd[NUM_FLG+RUN_WIDTH+CHG_W-1 -: NUM_FLG];
    assign w_cmd_run   = bus.cmd[RUN_WIDTH+CHG_W-1 -: RUN_WIDTH];
    assign w_cmd_acc   = bus.cmd_valid && r_cmd_ready;
    assign w_beat_acc  = (r_state == S_EMIT) && bus.src_ready;
    assign w_last      = r_rem == RUN_WIDTH'(1);

    // rem is 0 outside EMIT, so FIN can never leak onto an idle output
    always_comb begin
        w_src_flags    = '0;
        w_src_flags[0] = r_clr_pend;
        w_src_flags[1] = r_fin_req && w_last;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_fin_req   <= 1'b0;
            r_first     <= 1'b0;
            r_rem       <= '0;
            r_chg       <= '0;
            r_steps     <= '0;
        end else if (r_state == S_IDLE) begin
            r_cmd_ready <= !w_cmd_acc;
            if (w_cmd_acc) begin
                r_state    <= S_EMIT;
                r_rem      <= (w_cmd_run == '0) ? RUN_WIDTH'(1) : w_cmd_run;
                r_clr_pend <= w_cmd_flags[0];
                r_fin_req  <= w_cmd_flags[1];
                r_first    <= 1'b1;
                r_chg      <= bus.cmd[CHG_W-1:0];
            end
        end else if (w_beat_acc) begin
            r_rem      <= r_rem - RUN_WIDTH'(1);
            r_clr_pend <= 1'b0;
            r_first    <= 1'b0;
            r_steps    <= r_steps + CNT_WIDTH'(1);
            if (w_last) begin
                r_state     <= S_IDLE;
                r_cmd_ready <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.src_valid = r_state == S_EMIT;
    assign bus.busy      = r_state == S_EMIT;
    assign bus.src       = {w_src_flags, r_first ? r_chg : CHG_W'(0)};
    assign bus.steps     = r_steps;
endmodule
